// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster geometry, colour width and write-state encoding
package vga_pkg;

    localparam int REDUCED_PIXELS = 19;
    localparam int REDUCED_LINES  = 10;
    localparam int COLOR_W        = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    // Smallest width whose range covers every pixel slot of the frame.
    function automatic int addr_width(input int pixels, input int lines);
        int slots;
        int w;
        slots = pixels * lines;
        w = 1;
        while ((1 << w) < slots) w++;
        return w;
    endfunction

endpackage

// File: rtl/frame_writer_if.sv
// rtl/frame_writer_if.sv - pixel stream in and frame memory write port out
interface frame_writer_if #(
    parameter int addr_w = 8
);
    import vga_pkg::*;

    logic [COLOR_W-1:0] S_DATA;
    logic               S_SOF;
    logic               S_VALID;
    logic               S_READY;
    logic               WE;
    logic [addr_w-1:0]  WADDR;
    logic [COLOR_W-1:0] WDATA;
    logic               FRAME_DONE;
    logic               SOF_ERR;

    modport slave (
        input  S_DATA, S_SOF, S_VALID,
        output S_READY, WE, WADDR, WDATA, FRAME_DONE, SOF_ERR
    );

    modport master (
        output S_DATA, S_SOF, S_VALID,
        input  S_READY, WE, WADDR, WDATA, FRAME_DONE, SOF_ERR
    );

endinterface

// File: rtl/raster_addr_counter.sv
// rtl/raster_addr_counter.sv - pixel/line raster counter with running linear address
module raster_addr_counter #(
    parameter int pixels = 19,
    parameter int lines  = 10,
    parameter int addr_w = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              clear,
    input  logic              start1,
    input  logic              inc,
    output logic [addr_w-1:0] addr,
    output logic              last_pixel
);
    localparam int PIX_W  = $clog2(pixels);
    localparam int LINE_W = $clog2(lines);

    logic [PIX_W-1:0]  pixel;
    logic [LINE_W-1:0] line;
    logic              line_end;

    assign line_end   = (pixel == PIX_W'(pixels - 1));
    assign last_pixel = line_end && (line == LINE_W'(lines - 1));

    // The linear address advances alongside pixel/line so no multiplier is needed.
    always_ff @(posedge CLK) begin
        if (!RESET_N || clear) begin
            pixel <= '0;
            line  <= '0;
            addr  <= '0;
        end else if (start1) begin
            pixel <= PIX_W'(1);
            line  <= '0;
            addr  <= addr_w'(1);
        end else if (inc) begin
            if (line_end) begin
                pixel <= '0;
                line  <= last_pixel ? '0 : line + 1'b1;
            end else begin
                pixel <= pixel + 1'b1;
            end
            addr <= last_pixel ? '0 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - streams SOF-delimited pixel frames into the reduced frame memory
module frame_writer
    import vga_pkg::*;
#(
    parameter int reduced_pixels = REDUCED_PIXELS,
    parameter int reduced_lines  = REDUCED_LINES,
    parameter int addr_w         = addr_width(REDUCED_PIXELS, REDUCED_LINES)
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic WR_ALLOW,
    frame_writer_if.slave bus
);
    wr_state_e          state, state_n;
    logic               accept;
    logic               cnt_clear, cnt_start1, cnt_inc;
    logic [addr_w-1:0]  cnt_addr;
    logic               cnt_last;

    logic               we_q, we_n;
    logic [addr_w-1:0]  waddr_q, waddr_n;
    logic [COLOR_W-1:0] wdata_q, wdata_n;
    logic               done_q, done_n;
    logic               err_q, err_n;

    assign bus.S_READY = WR_ALLOW && RESET_N;
    assign accept      = bus.S_VALID && bus.S_READY;

    raster_addr_counter #(
        .pixels (reduced_pixels),
        .lines  (reduced_lines),
        .addr_w (addr_w)
    ) u_cnt (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .clear      (cnt_clear),
        .start1     (cnt_start1),
        .inc        (cnt_inc),
        .addr       (cnt_addr),
        .last_pixel (cnt_last)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            we_q    <= we_n;
            waddr_q <= waddr_n;
            wdata_q <= wdata_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_clear  = 1'b0;
        cnt_start1 = 1'b0;
        cnt_inc    = 1'b0;
        we_n       = 1'b0;
        waddr_n    = waddr_q;
        wdata_n    = wdata_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Beats before the first SOF are swallowed so a mid-frame join is harmless.
                if (accept && bus.S_SOF) begin
                    we_n       = 1'b1;
                    waddr_n    = '0;
                    wdata_n    = bus.S_DATA;
                    cnt_start1 = 1'b1;
                    state_n    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    we_n    = 1'b1;
                    wdata_n = bus.S_DATA;
                    if (bus.S_SOF) begin
                        err_n      = 1'b1;
                        waddr_n    = '0;
                        cnt_start1 = 1'b1;
                    end else begin
                        waddr_n = cnt_addr;
                        if (cnt_last) begin
                            done_n    = 1'b1;
                            cnt_clear = 1'b1;
                            state_n   = ST_IDLE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.WE         = we_q;
    assign bus.WADDR      = waddr_q;
    assign bus.WDATA      = wdata_q;
    assign bus.FRAME_DONE = done_q;
    assign bus.SOF_ERR    = err_q;

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Writes a streamed frame of colour bytes into the reduced-resolution frame memory that the display read path scans out.
- This is the write side of the image memory interface: the read path consumes one COLOR per pixel slot, and this block produces the memory contents.
- Accepts pixels on a valid/ready stream with a start-of-frame marker and converts them to linear write addresses in raster order.
- Writes are gated by an allow input, so the top level can restrict updates to blanking intervals.

Parameters:
- reduced_pixels, 19, pixels per stored line (must be ≥2).
- reduced_lines, 10, stored lines per frame (must be ≥2).
- addr_w, 8, write address width; must satisfy 2^addr_w ≥ reduced_pixels*reduced_lines.

Ports:
- CLK  in  1  system clock; everything is on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- WR_ALLOW  in  1  1 = writes permitted; 0 = stall input (S_READY low).
- S_DATA  in  8  pixel colour (RRRGGGBB, same format as COLOR).
- S_SOF  in  1  marks the first pixel of a frame; qualified by S_VALID.
- S_VALID  in  1  a beat is offered.
- S_READY  out  1  the block can accept a beat.
- WE  out  1  frame memory write strobe.
- WADDR  out  addr_w  linear address = line*reduced_pixels + pixel.
- WDATA  out  8  data to write.
- FRAME_DONE  out  1  one-cycle pulse, coincident with the WE of the last pixel.
- SOF_ERR  out  1  one-cycle pulse when S_SOF arrives mid-frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (RESET_N=0 at a rising edge):
  - S_READY, WE, WADDR, WDATA, FRAME_DONE and SOF_ERR all go to 0.
  - pixel and line counters go to 0; state goes to IDLE.
  - Reset mid-frame discards the partial frame with no pulses; memory contents are left as they are.
- S_READY = WR_ALLOW and not in reset. It is combinational from WR_ALLOW and the state and never depends on S_VALID.
- A beat is accepted when S_VALID & S_READY.
- All outputs except S_READY are registered. Latency from accept to WE is exactly 1 cycle. WE is high for exactly one cycle per written beat; WADDR and WDATA hold their value while WE=0.
- FSM states: IDLE, WRITE.
- IDLE:
  - Accepted beats with S_SOF=0 are consumed and dropped (no WE).
  - An accepted beat with S_SOF=1 is written to address 0. Then pixel=1, line=0 (or pixel=0, line=1 if reduced_pixels==1, which is excluded by the parameter rule), and the state goes to WRITE.
- WRITE, accepted beat with S_SOF=0:
  - The beat is written to the current address (line*reduced_pixels + pixel), kept as an incrementing address register rather than a multiplier.
  - pixel increments; when pixel == reduced_pixels-1 it wraps to 0 and line increments.
  - If that beat was pixel = reduced_pixels-1 and line = reduced_lines-1: FRAME_DONE pulses with its WE, counters clear, and the state goes to IDLE.
- WRITE, accepted beat with S_SOF=1 (early SOF):
  - SOF_ERR pulses with the WE of that beat.
  - The beat is written to address 0, counters restart at pixel=1, line=0, and the state stays WRITE.
  - The old partial frame is abandoned with no FRAME_DONE.
- WR_ALLOW=0 mid-frame: no accept, no WE, and counters and state hold. The frame resumes at the same address when WR_ALLOW returns to 1.
- Back-to-back accepts sustain one write per cycle. There are no bubbles and no internal buffering.
- S_VALID=1 with WR_ALLOW=0 causes no side effects.
- An SOF-marked beat on the last pixel slot counts as an early SOF: SOF_ERR pulses and there is no FRAME_DONE.
- The address never exceeds reduced_pixels*reduced_lines-1.

Decomposition:
- Shared package vga_pkg holds:
  - the default reduced_pixels/reduced_lines constants, shared with the read side;
  - the colour width constant (8) and the two-value state encoding;
  - a function computing the address width from the pixel and line counts.
- One natural sub-module, raster_addr_counter: pixel/line/linear-address counter with inc, clear and start-at-1 controls, plus a last-pixel flag. The read side can reuse it later.

Test Plan:
- Full frame: reset, WR_ALLOW=1, 190 beats S_DATA=i[7:0] (i=0..189) with S_SOF on i=0, S_VALID held high.
  - Expect 190 consecutive WE cycles, WADDR=i and WDATA=i[7:0], each one cycle after accept.
  - Expect FRAME_DONE only at WADDR=189, then IDLE.
- Pre-SOF garbage: 5 beats with S_SOF=0, then a frame as above.
  - Expect S_READY=1 during the garbage beats and no WE.
  - The first WE is at WADDR=0 with the SOF beat's data.
- Stall: during a frame, drop WR_ALLOW for 7 cycles after the beat at address 40.
  - Expect S_READY=0 and no WE for those 7 cycles.
  - The next accepted beat writes WADDR=41.
- Line wrap: check the beats at pixel 18 → 0.
  - WADDR must go 18→19 and 37→38, with no skipped addresses.
- Early SOF: SOF beat after address 50 has been written.
  - Expect SOF_ERR pulse and WADDR=0 on that beat, next WADDR=1, no FRAME_DONE until 190 more beats.
- Reset mid-frame: RESET_N=0 for 1 cycle after address 100.
  - Next cycle: all outputs are 0.
  - Beats without SOF are dropped; the next SOF beat writes address 0.
